// File: rtl/pipe_front_regs_if.sv
// pipe_front_regs_if: bundles the hazard-control, fetch, decode and
// execute-stage signals exchanged with the front-end pipeline registers.
// The master side is the surrounding datapath/hazard unit; the slave side
// is pipe_front_regs itself.
interface pipe_front_regs_if #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16
);
   logic              StallF;
   logic              StallD;
   logic              FlushD;
   logic              FlushE;
   logic              PCSrcE;
   logic [XLEN-1:0]   PCTargetE;
   logic [31:0]       InstrF;
   logic [XLEN-1:0]   PCF;
   logic [31:0]       InstrD;
   logic [XLEN-1:0]   PCD;
   logic [XLEN-1:0]   PCPlus4D;
   logic              ValidD;
   logic [4:0]        Rs1D;
   logic [4:0]        Rs2D;
   logic [4:0]        RdD;
   logic [CTRL_W-1:0] CtrlD;
   logic [XLEN-1:0]   RD1D;
   logic [XLEN-1:0]   RD2D;
   logic [XLEN-1:0]   ImmExtD;
   logic [CTRL_W-1:0] CtrlE;
   logic [XLEN-1:0]   RD1E;
   logic [XLEN-1:0]   RD2E;
   logic [XLEN-1:0]   ImmExtE;
   logic [XLEN-1:0]   PCE;
   logic [XLEN-1:0]   PCPlus4E;
   logic [4:0]        Rs1E;
   logic [4:0]        Rs2E;
   logic [4:0]        RdE;
   logic              ValidE;

   modport master (
      output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
      output CtrlD, RD1D, RD2D, ImmExtD,
      input  PCF, InstrD, PCD, PCPlus4D, ValidD, Rs1D, Rs2D, RdD,
      input  CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE
   );

   modport slave (
      input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
      input  CtrlD, RD1D, RD2D, ImmExtD,
      output PCF, InstrD, PCD, PCPlus4D, ValidD, Rs1D, Rs2D, RdD,
      output CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE
   );
endinterface

// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC register, IF/ID and ID/EX pipeline registers of the
// 5-stage RV32I pipeline. Applies the hazard unit's stall/flush controls and
// the execute-stage redirect. Every slot carries a valid bit so bubbles are
// explicit. Optional macro PIPE_PERF_CNT_EN adds saturating 32-bit
// StallCycles / FlushCycles / IssueCount counters.
module pipe_front_regs #(
   parameter int              XLEN     = 32,
   parameter int              CTRL_W   = 16,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   pipe_front_regs_if.slave    bus
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]         StallCycles,
   output logic [31:0]         FlushCycles,
   output logic [31:0]         IssueCount
`endif
);

   localparam logic [31:0] NopInstr = 32'h0000_0013;

   logic [XLEN-1:0]   pcF;
   logic [31:0]       instrD;
   logic [XLEN-1:0]   pcD;
   logic [XLEN-1:0]   pcPlus4D;
   logic              validD;
   logic [CTRL_W-1:0] ctrlE;
   logic [XLEN-1:0]   rd1E;
   logic [XLEN-1:0]   rd2E;
   logic [XLEN-1:0]   immExtE;
   logic [XLEN-1:0]   pcE;
   logic [XLEN-1:0]   pcPlus4E;
   logic [4:0]        rs1E;
   logic [4:0]        rs2E;
   logic [4:0]        rdE;
   logic              validE;
   logic [4:0]        rs1D;
   logic [4:0]        rs2D;
   logic [4:0]        rdD;

   // Register indices of a bubble read as x0 so they never match a real hazard
   always_comb begin
      rs1D = '0;
      rs2D = '0;
      rdD  = '0;
      if (validD) begin
         rs1D = instrD[19:15];
         rs2D = instrD[24:20];
         rdD  = instrD[11:7];
      end
   end

   // PC register: a taken redirect wins over a fetch stall, otherwise advance by 4
   always_ff @(posedge clk) begin
      if (!reset) begin
         pcF <= RESET_PC;
      end else if (bus.PCSrcE) begin
         pcF <= bus.PCTargetE;
      end else if (!bus.StallF) begin
         pcF <= pcF + XLEN'(4);
      end
   end

   // IF/ID register: a flush inserts a NOP bubble even while decode is stalled
   always_ff @(posedge clk) begin
      if (!reset) begin
         instrD   <= '0;
         pcD      <= '0;
         pcPlus4D <= '0;
         validD   <= 1'b0;
      end else if (bus.FlushD) begin
         instrD   <= NopInstr;
         pcD      <= '0;
         pcPlus4D <= '0;
         validD   <= 1'b0;
      end else if (!bus.StallD) begin
         instrD   <= bus.InstrF;
         pcD      <= pcF;
         pcPlus4D <= pcF + XLEN'(4);
         validD   <= 1'b1;
      end
   end

   // ID/EX register: never stalled, so each edge either takes a bubble or the decode slot
   always_ff @(posedge clk) begin
      if (!reset || bus.FlushE) begin
         ctrlE    <= '0;
         rd1E     <= '0;
         rd2E     <= '0;
         immExtE  <= '0;
         pcE      <= '0;
         pcPlus4E <= '0;
         rs1E     <= '0;
         rs2E     <= '0;
         rdE      <= '0;
         validE   <= 1'b0;
      end else begin
         ctrlE    <= bus.CtrlD;
         rd1E     <= bus.RD1D;
         rd2E     <= bus.RD2D;
         immExtE  <= bus.ImmExtD;
         pcE      <= pcD;
         pcPlus4E <= pcPlus4D;
         rs1E     <= rs1D;
         rs2E     <= rs2D;
         rdE      <= rdD;
         validE   <= validD;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   // Saturating event counters: decode stalls, flushes, and valid issues into E
   always_ff @(posedge clk) begin
      if (!reset) begin
         StallCycles <= '0;
         FlushCycles <= '0;
         IssueCount  <= '0;
      end else begin
         if (bus.StallD && (StallCycles != 32'hFFFF_FFFF)) begin
            StallCycles <= StallCycles + 32'd1;
         end
         if ((bus.FlushD || bus.FlushE) && (FlushCycles != 32'hFFFF_FFFF)) begin
            FlushCycles <= FlushCycles + 32'd1;
         end
         if (!bus.FlushE && validD && (IssueCount != 32'hFFFF_FFFF)) begin
            IssueCount <= IssueCount + 32'd1;
         end
      end
   end
`endif

   assign bus.PCF      = pcF;
   assign bus.InstrD   = instrD;
   assign bus.PCD      = pcD;
   assign bus.PCPlus4D = pcPlus4D;
   assign bus.ValidD   = validD;
   assign bus.Rs1D     = rs1D;
   assign bus.Rs2D     = rs2D;
   assign bus.RdD      = rdD;
   assign bus.CtrlE    = ctrlE;
   assign bus.RD1E     = rd1E;
   assign bus.RD2E     = rd2E;
   assign bus.ImmExtE  = immExtE;
   assign bus.PCE      = pcE;
   assign bus.PCPlus4E = pcPlus4E;
   assign bus.Rs1E     = rs1E;
   assign bus.Rs2E     = rs2E;
   assign bus.RdE      = rdE;
   assign bus.ValidE   = validE;

endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: directed scenarios followed by randomized stall/flush/
// redirect traffic, compared every cycle against a slot-level pipeline model.
// Build with +define+PIPE_PERF_CNT_EN to also check the event counters.
module tb_pipe_front_regs;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   pipe_front_regs_if #(.XLEN(32), .CTRL_W(16)) bus ();

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] StallCycles;
   logic [31:0] FlushCycles;
   logic [31:0] IssueCount;
`endif

   pipe_front_regs #(.XLEN(32), .CTRL_W(16), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef PIPE_PERF_CNT_EN
      ,
      .StallCycles (StallCycles),
      .FlushCycles (FlushCycles),
      .IssueCount  (IssueCount)
`endif
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
   } dSlotT;

   typedef struct packed {
      logic        valid;
      logic [15:0] ctrl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pcPlus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } eSlotT;

   logic [31:0] mPc;
   dSlotT       mD;
   eSlotT       mE;
   longint      mStall;
   longint      mFlush;
   longint      mIssue;

   // A bubble in decode reports x0 for every register field
   function automatic logic [4:0] fieldOf(input dSlotT s, input int lo);
      logic [31:0] w;
      w = s.instr;
      return s.valid ? w[lo +: 5] : 5'd0;
   endfunction

   // PC+4 is only meaningful for a real instruction; bubbles carry zeros
   function automatic logic [31:0] plus4Of(input dSlotT s);
      return s.valid ? s.pc + 32'd4 : 32'd0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic longint sat32(input longint v);
      return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
   endfunction

   task automatic modelStep();
      dSlotT nD;
      eSlotT nE;
      if (!reset) begin
         mPc    = 32'h0;
         mD     = '0;
         mE     = '0;
         mStall = 0;
         mFlush = 0;
         mIssue = 0;
      end else begin
         if (bus.StallD) mStall = sat32(mStall + 1);
         if (bus.FlushD || bus.FlushE) mFlush = sat32(mFlush + 1);
         if (!bus.FlushE && mD.valid) mIssue = sat32(mIssue + 1);
         if (bus.FlushE) begin
            nE = '0;
         end else begin
            nE.valid   = mD.valid;
            nE.ctrl    = bus.CtrlD;
            nE.rd1     = bus.RD1D;
            nE.rd2     = bus.RD2D;
            nE.imm     = bus.ImmExtD;
            nE.pc      = mD.pc;
            nE.pcPlus4 = plus4Of(mD);
            nE.rs1     = fieldOf(mD, 15);
            nE.rs2     = fieldOf(mD, 20);
            nE.rd      = fieldOf(mD, 7);
         end
         if (bus.FlushD)      nD = '{valid: 1'b0, instr: 32'h13, pc: 32'h0};
         else if (bus.StallD) nD = mD;
         else                 nD = '{valid: 1'b1, instr: bus.InstrF, pc: mPc};
         if (bus.PCSrcE)      mPc = bus.PCTargetE;
         else if (!bus.StallF) mPc = mPc + 32'd4;
         mD = nD;
         mE = nE;
      end
   endtask

   task automatic compareAll();
      checkOutput("PCF", bus.PCF, mPc);
      checkOutput("InstrD", bus.InstrD, mD.instr);
      checkOutput("PCD", bus.PCD, mD.pc);
      checkOutput("PCPlus4D", bus.PCPlus4D, plus4Of(mD));
      checkOutput("ValidD", 32'(bus.ValidD), 32'(mD.valid));
      checkOutput("Rs1D", 32'(bus.Rs1D), 32'(fieldOf(mD, 15)));
      checkOutput("Rs2D", 32'(bus.Rs2D), 32'(fieldOf(mD, 20)));
      checkOutput("RdD", 32'(bus.RdD), 32'(fieldOf(mD, 7)));
      checkOutput("CtrlE", 32'(bus.CtrlE), 32'(mE.ctrl));
      checkOutput("RD1E", bus.RD1E, mE.rd1);
      checkOutput("RD2E", bus.RD2E, mE.rd2);
      checkOutput("ImmExtE", bus.ImmExtE, mE.imm);
      checkOutput("PCE", bus.PCE, mE.pc);
      checkOutput("PCPlus4E", bus.PCPlus4E, mE.pcPlus4);
      checkOutput("Rs1E", 32'(bus.Rs1E), 32'(mE.rs1));
      checkOutput("Rs2E", 32'(bus.Rs2E), 32'(mE.rs2));
      checkOutput("RdE", 32'(bus.RdE), 32'(mE.rd));
      checkOutput("ValidE", 32'(bus.ValidE), 32'(mE.valid));
`ifdef PIPE_PERF_CNT_EN
      checkOutput("StallCycles", StallCycles, 32'(mStall));
      checkOutput("FlushCycles", FlushCycles, 32'(mFlush));
      checkOutput("IssueCount", IssueCount, 32'(mIssue));
`endif
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model at the
   // rising edge, and compare shortly after
   task automatic applyStimulus(input logic rstN, input logic sF, input logic sD,
                                input logic fD, input logic fE, input logic pcs,
                                input logic [31:0] tgt, input logic [31:0] instr);
      @(negedge clk);
      reset         = rstN;
      bus.StallF    = sF;
      bus.StallD    = sD;
      bus.FlushD    = fD;
      bus.FlushE    = fE;
      bus.PCSrcE    = pcs;
      bus.PCTargetE = tgt;
      bus.InstrF    = instr;
      bus.CtrlD     = 16'($urandom);
      bus.RD1D      = $urandom;
      bus.RD2D      = $urandom;
      bus.ImmExtD   = $urandom;
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      mPc = '0; mD = '0; mE = '0;
      mStall = 0; mFlush = 0; mIssue = 0;

      // Reset for three cycles with a toggling instruction bus
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 0, 0, 0, 0, 0, 32'h0, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
      end
      checkOutput("rst_PCF", bus.PCF, 32'h0);
      checkOutput("rst_ValidD", 32'(bus.ValidD), 32'h0);
      checkOutput("rst_ValidE", 32'(bus.ValidE), 32'h0);
      checkOutput("rst_InstrD", bus.InstrD, 32'h0);

      // Straight-line fetch from 0, 4, 8
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 32'h0, 32'h0010_0113);
      checkOutput("first_PCF", bus.PCF, 32'h4);
      checkOutput("first_ValidD", 32'(bus.ValidD), 32'h1);
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 32'h0, 32'h0020_0193);
      checkOutput("second_ValidE", 32'(bus.ValidE), 32'h1);
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 32'h0, 32'h0050_0093);
      checkOutput("sl_InstrD", bus.InstrD, 32'h0050_0093);
      checkOutput("sl_RdD", 32'(bus.RdD), 32'h1);
      checkOutput("sl_PCD", bus.PCD, 32'h8);
      checkOutput("sl_PCPlus4D", bus.PCPlus4D, 32'hC);
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 32'h0, 32'h0030_0213);
      checkOutput("sl_RdE", 32'(bus.RdE), 32'h1);
      checkOutput("sl_PCE", bus.PCE, 32'h8);
      checkOutput("sl_PCF10", bus.PCF, 32'h10);

      // Load-use: hold PC and IF/ID, bubble into E, then resume
      applyStimulus(1'b1, 1, 1, 0, 1, 0, 32'h0, 32'h0040_0293);
      checkOutput("lu_PCF", bus.PCF, 32'h10);
      checkOutput("lu_InstrD", bus.InstrD, 32'h0030_0213);
      checkOutput("lu_PCD", bus.PCD, 32'hC);
      checkOutput("lu_ValidE", 32'(bus.ValidE), 32'h0);
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 32'h0, 32'h0060_0313);
      checkOutput("lu_resume_PCE", bus.PCE, 32'hC);
      checkOutput("lu_resume_PCD", bus.PCD, 32'h10);
      checkOutput("lu_resume_PCF", bus.PCF, 32'h14);

      // Taken branch with a simultaneous fetch stall
      applyStimulus(1'b1, 1, 0, 1, 1, 1, 32'h40, 32'h0070_0393);
      checkOutput("br_PCF", bus.PCF, 32'h40);
      checkOutput("br_ValidD", 32'(bus.ValidD), 32'h0);
      checkOutput("br_ValidE", 32'(bus.ValidE), 32'h0);
      checkOutput("br_InstrD", bus.InstrD, 32'h0000_0013);

      // PC wraps from the top of the address space
      applyStimulus(1'b1, 0, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'h0);
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 32'h0, 32'h0080_0413);
      checkOutput("wrap_PCF", bus.PCF, 32'h0);
      checkOutput("wrap_PCD", bus.PCD, 32'hFFFF_FFFC);
      checkOutput("wrap_PCPlus4D", bus.PCPlus4D, 32'h0);

      // Reset asserted together with a stall clears everything
      applyStimulus(1'b0, 1, 1, 0, 0, 0, 32'h0, 32'h1234_5678);
      checkOutput("rstStall_PCF", bus.PCF, 32'h0);
      checkOutput("rstStall_ValidD", 32'(bus.ValidD), 32'h0);
      checkOutput("rstStall_InstrD", bus.InstrD, 32'h0);
      checkOutput("rstStall_ValidE", 32'(bus.ValidE), 32'h0);

      // Five decode stalls then two flush cycles after a clean reset
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1, 1, 0, 0, 0, 32'h0, $urandom);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 0, 0, 0, 1, 0, 32'h0, $urandom);
`ifdef PIPE_PERF_CNT_EN
      checkOutput("perf_Stall5", StallCycles, 32'd5);
      checkOutput("perf_Flush2", FlushCycles, 32'd2);
`endif

      // Randomized traffic including occasional reset pulses
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 49) != 0),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 6) == 0),
                       $urandom & 32'hFFFF_FFFC,
                       $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
